axi_spy_drain: RTL and testbench

- Reader side of the AXI spy capture FIFOs. Drains the four spy FIFOs (AR, AW, W, R) into one valid/ready output stream for a debug host or trace sink.
- Each output beat carries the captured word, a channel tag and a sequence number.
- Sits between the spy block's FIFO read ports and the debug readout path.
- Round-robin arbitration prevents a busy channel from starving the others.

---
 rtl/axi_spy_pkg.sv | 18 +
 rtl/spy_rr_arb.sv | 30 +++
 rtl/axi_spy_drain.sv | 138 +++++++++++++
 tb/tb_axi_spy_drain.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_spy_pkg.sv
// rtl/axi_spy_pkg.sv - shared channel/state types for the AXI spy drain
package axi_spy_pkg;

    localparam int SPY_NUM_CHAN = 4;

    typedef enum logic [1:0] {
        SPY_AR = 2'd0,
        SPY_AW = 2'd1,
        SPY_W  = 2'd2,
        SPY_R  = 2'd3
    } spy_chan_e;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_SEND = 1'b1
    } drain_state_e;

endpackage

// File: rtl/spy_rr_arb.sv
// rtl/spy_rr_arb.sv - combinational 4-way round-robin grant starting after rr_last
module spy_rr_arb
    import axi_spy_pkg::*;
(
    input  logic [SPY_NUM_CHAN-1:0] req,
    input  logic [1:0]              rr_last,
    output logic [SPY_NUM_CHAN-1:0] gnt_onehot,
    output spy_chan_e               gnt_idx,
    output logic                    gnt_valid
);

    logic [1:0] cand;

    // Scan rr_last+1 .. rr_last+4; the 2-bit add wraps modulo 4 on its own.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = SPY_AR;
        gnt_valid  = 1'b0;
        cand       = rr_last;
        for (int i = 1; i <= SPY_NUM_CHAN; i++) begin
            cand = rr_last + 2'(i);
            if (!gnt_valid && req[cand]) begin
                gnt_valid        = 1'b1;
                gnt_idx          = spy_chan_e'(cand);
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_spy_drain.sv
// rtl/axi_spy_drain.sv - drains AR/AW/W/R spy FIFOs into one tagged stream; AXI_SPY_DRAIN_TIMESTAMP_EN adds out_ts
module axi_spy_drain
    import axi_spy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEQ_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drain_en,
    input  logic                  ar_empty,
    input  logic [ADDR_WIDTH-1:0] ar_data,
    output logic                  ar_pop,
    input  logic                  aw_empty,
    input  logic [ADDR_WIDTH-1:0] aw_data,
    output logic                  aw_pop,
    input  logic                  w_empty,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_pop,
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_chan,
    output logic [SEQ_WIDTH-1:0]  out_seq,
`ifdef AXI_SPY_DRAIN_TIMESTAMP_EN
    output logic [31:0]           out_ts,
`endif
    output logic                  busy
);

    drain_state_e              state;
    drain_state_e              state_nxt;
    logic [1:0]                rr_last;
    logic [SPY_NUM_CHAN-1:0]   req;
    logic [SPY_NUM_CHAN-1:0]   gnt_onehot;
    spy_chan_e                 gnt_idx;
    logic                      gnt_valid;
    logic                      handshake;
    logic                      pop_en;
    logic [SPY_NUM_CHAN-1:0]   pop_vec;
    logic [DATA_WIDTH-1:0]     head_data;

    assign req       = {~r_empty, ~w_empty, ~aw_empty, ~ar_empty};
    assign out_valid = (state == DRAIN_SEND);
    assign busy      = (state == DRAIN_SEND);
    assign handshake = out_valid & out_ready;

    spy_rr_arb u_arb (
        .req        (req),
        .rr_last    (rr_last),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    always_comb begin
        state_nxt = state;
        pop_en    = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                if (drain_en && gnt_valid) begin
                    pop_en    = 1'b1;
                    state_nxt = DRAIN_SEND;
                end
            end
            DRAIN_SEND: begin
                // Reload back-to-back on the handshake cycle so no bubble appears.
                if (handshake) begin
                    if (drain_en && gnt_valid) begin
                        pop_en = 1'b1;
                    end else begin
                        state_nxt = DRAIN_IDLE;
                    end
                end
            end
            default: state_nxt = DRAIN_IDLE;
        endcase
    end

    // A popped word would be lost while reset holds the output registers.
    assign pop_vec = (pop_en && reset) ? gnt_onehot : '0;
    assign ar_pop  = pop_vec[SPY_AR];
    assign aw_pop  = pop_vec[SPY_AW];
    assign w_pop   = pop_vec[SPY_W];
    assign r_pop   = pop_vec[SPY_R];

    always_comb begin
        head_data = '0;
        case (gnt_idx)
            SPY_AR:  head_data = DATA_WIDTH'(ar_data);
            SPY_AW:  head_data = DATA_WIDTH'(aw_data);
            SPY_W:   head_data = w_data;
            SPY_R:   head_data = r_data;
            default: head_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DRAIN_IDLE;
            out_data <= '0;
            out_chan <= 2'd0;
            out_seq  <= '0;
            rr_last  <= 2'd3;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                out_seq <= out_seq + SEQ_WIDTH'(1);
            end
            if (pop_en) begin
                out_data <= head_data;
                out_chan <= gnt_idx;
                rr_last  <= gnt_idx;
            end
        end
    end

`ifdef AXI_SPY_DRAIN_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt <= '0;
            out_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (pop_en) begin
                out_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_spy_drain.sv
// tb/tb_axi_spy_drain.sv - self-checking bench for axi_spy_drain with queue-based FIFO and stream model
module tb_axi_spy_drain;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int SW = 3;
    localparam int SEQ_MOD = 1 << SW;

    logic          clk = 1'b0;
    logic          reset;
    logic          drain_en;
    logic          ar_empty, aw_empty, w_empty, r_empty;
    logic [AW-1:0] ar_data, aw_data;
    logic [DW-1:0] w_data, r_data;
    logic          ar_pop, aw_pop, w_pop, r_pop;
    logic          out_valid, out_ready, busy;
    logic [DW-1:0] out_data;
    logic [1:0]    out_chan;
    logic [SW-1:0] out_seq;
`ifdef AXI_SPY_DRAIN_TIMESTAMP_EN
    logic [31:0]   out_ts;
`endif

    axi_spy_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEQ_WIDTH(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .drain_en  (drain_en),
        .ar_empty  (ar_empty),
        .ar_data   (ar_data),
        .ar_pop    (ar_pop),
        .aw_empty  (aw_empty),
        .aw_data   (aw_data),
        .aw_pop    (aw_pop),
        .w_empty   (w_empty),
        .w_data    (w_data),
        .w_pop     (w_pop),
        .r_empty   (r_empty),
        .r_data    (r_data),
        .r_pop     (r_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_seq   (out_seq),
`ifdef AXI_SPY_DRAIN_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] ar_q[$], aw_q[$], w_q[$], r_q[$];
    int vectors = 0;
    int miscompares = 0;

    bit          m_valid;
    logic [31:0] m_data;
    int          m_chan, m_seq, m_rr;

    typedef struct {
        bit          drain_en;
        bit          ready;
        bit          exp_valid;
        int          exp_chan;
        int          exp_seq;
        logic [31:0] exp_data;
        logic [3:0]  exp_pops;
    } vec_t;
    vec_t tbl[13];

    function automatic int qsize(int c);
        case (c)
            0: return ar_q.size();
            1: return aw_q.size();
            2: return w_q.size();
            default: return r_q.size();
        endcase
    endfunction

    function automatic logic [31:0] qfront(int c);
        case (c)
            0: return ar_q[0];
            1: return aw_q[0];
            2: return w_q[0];
            default: return r_q[0];
        endcase
    endfunction

    task automatic refresh();
        ar_empty = (ar_q.size() == 0);
        aw_empty = (aw_q.size() == 0);
        w_empty  = (w_q.size() == 0);
        r_empty  = (r_q.size() == 0);
        ar_data  = ar_empty ? '0 : ar_q[0][AW-1:0];
        aw_data  = aw_empty ? '0 : aw_q[0][AW-1:0];
        w_data   = w_empty ? '0 : w_q[0];
        r_data   = r_empty ? '0 : r_q[0];
    endtask

    task automatic qpop(int c);
        case (c)
            0: void'(ar_q.pop_front());
            1: void'(aw_q.pop_front());
            2: void'(w_q.pop_front());
            default: void'(r_q.pop_front());
        endcase
    endtask

    task automatic push(int c, logic [31:0] v);
        logic [31:0] mv;
        mv = (c < 2) ? (v & ((32'd1 << AW) - 32'd1)) : v;
        case (c)
            0: ar_q.push_back(mv);
            1: aw_q.push_back(mv);
            2: w_q.push_back(mv);
            default: r_q.push_back(mv);
        endcase
        refresh();
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_seq   = 0;
        m_rr    = 3;
    endtask

    // Called at posedge+1; checks at the negedge, then advances model and FIFOs past the next posedge.
    task automatic cycle();
        int         g;
        logic [3:0] exp_pop;
        @(negedge clk);
        g = -1;
        exp_pop = '0;
        if (drain_en && (!m_valid || out_ready)) begin
            for (int i = 1; i <= 4; i++) begin
                if (g < 0 && qsize((m_rr + i) % 4) > 0) g = (m_rr + i) % 4;
            end
        end
        if (g >= 0) exp_pop[g] = 1'b1;
        check("valid", 32'(out_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_valid));
        check("pops", 32'({r_pop, w_pop, aw_pop, ar_pop}), 32'(exp_pop));
        check("seq", 32'(out_seq), m_seq);
        if (m_valid) begin
            check("data", out_data, m_data);
            check("chan", 32'(out_chan), m_chan);
        end
        @(posedge clk);
        if (m_valid && out_ready) begin
            m_seq   = (m_seq + 1) % SEQ_MOD;
            m_valid = 1'b0;
        end
        if (g >= 0) begin
            m_data  = qfront(g);
            m_chan  = g;
            m_rr    = g;
            m_valid = 1'b1;
            qpop(g);
        end
        #1;
        refresh();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        drain_en  = 1'b0;
        out_ready = 1'b0;
        ar_q.delete();
        aw_q.delete();
        w_q.delete();
        r_q.delete();
        refresh();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] base [4];
        base[0] = 32'h0A00_0000;
        base[1] = 32'h0B00_0000;
        base[2] = 32'hC000_0000;
        base[3] = 32'hD000_0000;

        // Reset held with every FIFO non-empty
        reset = 1'b0;
        drain_en = 1'b1;
        out_ready = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) push(c, base[c] + 32'h100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pops", 32'({r_pop, w_pop, aw_pop, ar_pop}), 32'd0);
        check("rst_seq", 32'(out_seq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        drain_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) cycle();
        drain_en = 1'b1;
        repeat (6) cycle();

        // Single AR word, one-cycle latency
        do_reset();
        push(0, 32'h1000_0040);
        drain_en = 1'b1;
        out_ready = 1'b1;
        cycle();
        #2;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", out_data, 32'h1000_0040);
        check("single_chan", 32'(out_chan), 32'd0);
        check("single_seq", 32'(out_seq), 32'd0);
        cycle();
        #2;
        check("single_idle", 32'(out_valid), 32'd0);
        cycle();

        // Round-robin with backpressure, table-driven
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) push(c, base[c] + 32'(k));
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 0, 32'h0,         4'b0001};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 0, 0, 32'h0A00_0000, 4'b0010};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1, 1, 32'h0B00_0000, 4'b0100};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2, 2, 32'hC000_0000, 4'b1000};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 3, 3, 32'hD000_0000, 4'b0001};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 0, 4, 32'h0A00_0001, 4'b0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 0, 4, 32'h0A00_0001, 4'b0000};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 0, 4, 32'h0A00_0001, 4'b0000};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 0, 4, 32'h0A00_0001, 4'b0010};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1, 5, 32'h0B00_0001, 4'b0100};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2, 6, 32'hC000_0001, 4'b1000};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3, 7, 32'hD000_0001, 4'b0000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 0, 0, 32'h0,         4'b0000};
        for (int i = 0; i < 13; i++) begin
            drain_en  = tbl[i].drain_en;
            out_ready = tbl[i].ready;
            #2;
            check("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
            check("tbl_pops", 32'({r_pop, w_pop, aw_pop, ar_pop}), 32'(tbl[i].exp_pops));
            check("tbl_seq", 32'(out_seq), tbl[i].exp_seq);
            if (tbl[i].exp_valid) begin
                check("tbl_chan", 32'(out_chan), tbl[i].exp_chan);
                check("tbl_data", out_data, tbl[i].exp_data);
            end
            cycle();
        end

        // Reset asserted mid-SEND discards the beat
        do_reset();
        for (int k = 0; k < 3; k++) push(3, 32'h5500_0000 + 32'(k));
        drain_en = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();
        out_ready = 1'b0;
        repeat (2) cycle();
        #2;
        check("abort_seq_pre", 32'(out_seq), 32'd2);
        check("abort_valid_pre", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seq", 32'(out_seq), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        refresh();

        // drain_en drop during SEND lets the beat finish, then holds off pops
        do_reset();
        push(2, 32'h7777_0001);
        push(2, 32'h7777_0002);
        drain_en = 1'b1;
        out_ready = 1'b0;
        cycle();
        drain_en = 1'b0;
        out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            #2;
            check("den_wpop", 32'(w_pop), 32'd0);
            check("den_valid", 32'(out_valid), 32'd0);
            cycle();
        end
        drain_en = 1'b1;
        repeat (3) cycle();

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) < 45) push(int'($urandom_range(0, 3)), $urandom);
            drain_en  = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain_en = 1'b1;
        out_ready = 1'b1;
        repeat (40) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
